// File: rtl/num_display_driver.sv
// num_display_driver: registered multi-digit active-low 7-segment driver.
// Accepts one word per valid/ready handshake and shows it in hex or decimal.
// Decimal uses a serial double-dabble converter, one bit per clock.
// Optional feature: define NUM_DISPLAY_LZB_EN for leading-zero blanking.
module num_display_driver #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_dec,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    busy,
  output logic                    ovf
);

  // BCD register holds every decimal digit of 2^DATA_W-1 (log10(2) < 1/3),
  // and at least NUM_DIGITS digits so the display slice always exists.
  localparam int unsigned BCD_MIN = DATA_W / 3 + 1;
  localparam int unsigned BCD_D   = (BCD_MIN > NUM_DIGITS) ? BCD_MIN : NUM_DIGITS;
  localparam int unsigned BCD_W   = 4 * BCD_D;
  localparam int unsigned PAD_W   = (DATA_W > 4 * NUM_DIGITS) ? DATA_W : 4 * NUM_DIGITS;
  localparam int unsigned CNT_W   = $clog2(DATA_W);

`ifdef NUM_DISPLAY_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    UPDATE
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   sh;
  logic [BCD_W-1:0]    bcd;
  logic [BCD_W-1:0]    bcd_adj;
  logic                dec_q;
  logic [CNT_W-1:0]    cnt;

  logic [PAD_W-1:0]        pad;
  logic [4*NUM_DIGITS-1:0] nib;
  logic                    nxt_ovf;
  logic [7*NUM_DIGITS-1:0] nxt_hex;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign in_ready = (state == IDLE);

  // Double-dabble add-3 correction applied to every BCD digit before the shift
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < BCD_D; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Select displayed nibbles and detect overflow for the latched word
  always_comb begin
    pad     = PAD_W'(sh);
    nib     = '0;
    nxt_ovf = 1'b0;
    if (dec_q) begin
      nib = bcd[4*NUM_DIGITS-1:0];
      for (int unsigned i = NUM_DIGITS; i < BCD_D; i++) begin
        if (bcd[4*i +: 4] != 4'd0) begin
          nxt_ovf = 1'b1;
        end
      end
    end else begin
      nib = pad[4*NUM_DIGITS-1:0];
      for (int unsigned i = 4 * NUM_DIGITS; i < PAD_W; i++) begin
        if (pad[i]) begin
          nxt_ovf = 1'b1;
        end
      end
    end
  end

  // Segment rendering, scanning from the top digit so blanking stops at the first nonzero
  always_comb begin : render
    int unsigned d;
    logic        seen;
    nxt_hex = '1;
    seen    = 1'b0;
    d       = 0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      d = NUM_DIGITS - 1 - j;
      if (nib[4*d +: 4] != 4'd0 || d == 0) begin
        seen = 1'b1;
      end
      if (nxt_ovf) begin
        nxt_hex[7*d +: 7] = SEG_DASH;
      end else if (LZB && !seen) begin
        nxt_hex[7*d +: 7] = SEG_BLANK;
      end else begin
        nxt_hex[7*d +: 7] = seg7(nib[4*d +: 4]);
      end
    end
  end

  // Control FSM: accept, optional serial conversion, then a single display update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sh      <= '0;
      bcd     <= '0;
      dec_q   <= 1'b0;
      cnt     <= '0;
      hex_out <= '1;
      busy    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh    <= in_data;
            bcd   <= '0;
            dec_q <= in_dec;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= in_dec ? CONVERT : UPDATE;
          end
        end
        CONVERT: begin
          sh  <= {sh[DATA_W-2:0], 1'b0};
          bcd <= {bcd_adj[BCD_W-2:0], sh[DATA_W-1]};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            state <= UPDATE;
          end
        end
        UPDATE: begin
          hex_out <= nxt_hex;
          ovf     <= nxt_ovf;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_num_display_driver.sv
// Bench for num_display_driver: arithmetic reference model compared every cycle,
// plus directed vectors with literal segment patterns. Two instances (4 and 3 digits)
// share the same stimulus.
module tb_num_display_driver;

  localparam int unsigned DW = 16;

`ifdef NUM_DISPLAY_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_dec   = 1'b0;
  logic [15:0] in_data  = '0;

  logic        in_ready, busy, ovf;
  logic [27:0] hex_out;
  logic        in_ready3, busy3, ovf3;
  logic [20:0] hex_out3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  num_display_driver #(.DATA_W(16), .NUM_DIGITS(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dec(in_dec), .hex_out(hex_out), .busy(busy), .ovf(ovf)
  );

  num_display_driver #(.DATA_W(16), .NUM_DIGITS(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .in_dec(in_dec), .hex_out(hex_out3), .busy(busy3), .ovf(ovf3)
  );

  logic [6:0] tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ovf(input int unsigned v, input bit dec, input int unsigned nd);
    longint unsigned lim;
    lim = 1;
    for (int i = 0; i < int'(nd); i++) lim = lim * (dec ? 10 : 16);
    return (longint'(v) >= lim);
  endfunction

  function automatic logic [55:0] model_hex(input int unsigned v, input bit dec, input int unsigned nd);
    logic [55:0]     r;
    longint unsigned p, base, q;
    int unsigned     dig;
    r    = '1;
    base = dec ? 10 : 16;
    if (model_ovf(v, dec, nd)) begin
      for (int i = 0; i < int'(nd); i++) r[7*i +: 7] = 7'b0111111;
      return r;
    end
    p = 1;
    for (int i = 0; i < int'(nd); i++) begin
      q   = longint'(v) / p;
      dig = int'(q % base);
      if (LZB && i > 0 && q == 0) r[7*i +: 7] = 7'b1111111;
      else r[7*i +: 7] = tbl[dig[3:0]];
      p = p * base;
    end
    return r;
  endfunction

  // reference model: remaining-latency counter and value-level rendering
  int unsigned m_rem  = 0;
  logic        m_busy = 1'b0;
  int unsigned m_val  = 0;
  bit          m_dec  = 1'b0;
  logic [27:0] m_hex  = '1;
  logic        m_ovf  = 1'b0;
  logic [20:0] m_hex3 = '1;
  logic        m_ovf3 = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rem  <= 0;
      m_busy <= 1'b0;
      m_hex  <= '1;
      m_ovf  <= 1'b0;
      m_hex3 <= '1;
      m_ovf3 <= 1'b0;
    end else if (m_rem == 0) begin
      if (in_valid) begin
        m_val  <= in_data;
        m_dec  <= in_dec;
        m_rem  <= in_dec ? DW + 1 : 1;
        m_busy <= 1'b1;
      end
    end else begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_busy <= 1'b0;
        m_hex  <= 28'(model_hex(m_val, m_dec, 4));
        m_ovf  <= model_ovf(m_val, m_dec, 4);
        m_hex3 <= 21'(model_hex(m_val, m_dec, 3));
        m_ovf3 <= model_ovf(m_val, m_dec, 3);
      end
    end
  end

  always @(negedge clk) begin
    chk("ready",  in_ready,  m_rem == 0);
    chk("busy",   busy,      m_busy);
    chk("hex",    hex_out,   m_hex);
    chk("ovf",    ovf,       m_ovf);
    chk("ready3", in_ready3, m_rem == 0);
    chk("busy3",  busy3,     m_busy);
    chk("hex3",   hex_out3,  m_hex3);
    chk("ovf3",   ovf3,      m_ovf3);
  end

  task automatic send(input logic [15:0] d, input logic dec);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_dec   = dec;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: in_ready=%b expected 1 within 100 cycles", in_ready);
    end
  endtask

  typedef struct { logic [15:0] d; logic dec; } vec_t;
  vec_t vecs [6] = '{
    '{16'd9999,  1'b1}, '{16'd10000, 1'b1}, '{16'h0FFF, 1'b0},
    '{16'h1000,  1'b0}, '{16'h0040,  1'b0}, '{16'd305,  1'b1}
  };

  initial begin
    int nb;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hex",   hex_out,  28'hFFFFFFF);
    chk("rst_busy",  busy,     1'b0);
    chk("rst_ovf",   ovf,      1'b0);
    chk("rst_ready", in_ready, 1'b1);
    reset = 1'b0;

    // hex BEEF, two-edge latency
    send(16'hBEEF, 1'b0);
    @(negedge clk);
    chk("beef_lat_hold", hex_out, 28'hFFFFFFF);
    chk("beef_lat_busy", busy, 1'b1);
    @(negedge clk);
    chk("beef_hex", hex_out, 28'b0000011_0000110_0000110_0001110);
    chk("beef_ovf", ovf, 1'b0);
    wait_idle();

    // decimal 1234 with a competing word offered while busy
    send(16'd1234, 1'b1);
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    in_dec   = 1'b0;
    nb = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 10) in_valid = 1'b0;
      if (busy) nb++;
      else break;
    end
    chk("d1234_busy_cycles", nb, 17);
    chk("d1234_hex", hex_out, 28'b1111001_0100100_0110000_0011001);
    chk("d1234_ovf", ovf, 1'b0);
    chk("d1234_ovf3", ovf3, 1'b1);

    // overflow cases
    send(16'd65535, 1'b1);
    wait_idle();
    chk("d65535_hex", hex_out, {4{7'b0111111}});
    chk("d65535_ovf", ovf, 1'b1);
    send(16'h1234, 1'b0);
    wait_idle();
    chk("h1234_ovf3", ovf3, 1'b1);
    chk("h1234_hex3", hex_out3, {3{7'b0111111}});
    chk("h1234_ovf", ovf, 1'b0);
    chk("h1234_hex", hex_out, 28'b1111001_0100100_0110000_0011001);

    // reset during cycle 8 of a decimal conversion
    send(16'd9999, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_hex",   hex_out,  28'hFFFFFFF);
    chk("abort_busy",  busy,     1'b0);
    chk("abort_ready", in_ready, 1'b1);
    chk("abort_ovf",   ovf,      1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(16'h00A5, 1'b0);
    wait_idle();
    if (LZB) chk("a5_hex", hex_out, 28'b1111111_1111111_0001000_0010010);
    else     chk("a5_hex", hex_out, 28'b1000000_1000000_0001000_0010010);

    // decimal zero
    send(16'd0, 1'b1);
    wait_idle();
    if (LZB) chk("zero_hex", hex_out, 28'b1111111_1111111_1111111_1000000);
    else     chk("zero_hex", hex_out, 28'b1000000_1000000_1000000_1000000);

    // boundary vectors checked by the model
    foreach (vecs[i]) begin
      send(vecs[i].d, vecs[i].dec);
      wait_idle();
    end
    chk("h0040_ovf3", ovf3, 1'b0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish by %0t", $time);
    $fatal(1);
  end

endmodule
